// File: rtl/dmem_responder.sv
// Line-granular data-memory responder: one read or write in flight, fixed-latency single-cycle ack.
// Optional address checking (err_o) is compiled in with `define DMEM_RESPONDER_ADDR_CHECK_EN.
module dmem_responder #(
    parameter int LINE_WIDTH = 256,
    parameter int ADDR_WIDTH = 32,
    parameter int DEPTH      = 512,
    parameter int LATENCY    = 10
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  enable_i,
    input  logic                  write_i,
    input  logic [ADDR_WIDTH-1:0] addr_i,
    input  logic [LINE_WIDTH-1:0] data_i,
    output logic                  ack_o,
`ifdef DMEM_RESPONDER_ADDR_CHECK_EN
    output logic                  err_o,
`endif
    output logic [LINE_WIDTH-1:0] data_o
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int CNT_W = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        ACK  = 2'd2
    } state_t;

    state_t                state_q;
    logic [CNT_W-1:0]      cnt_q;
    logic [IDX_W-1:0]      idx_q;
    logic                  wr_q;
    logic [LINE_WIDTH-1:0] wdata_q;
    logic                  ack_q;
    logic [LINE_WIDTH-1:0] rdata_q;
    logic                  err_lat_q;

    logic [LINE_WIDTH-1:0] mem_q [DEPTH];

    logic [IDX_W-1:0]      in_idx;
    logic                  in_err;
    logic                  go_ack;
    logic [IDX_W-1:0]      acc_idx;
    logic                  acc_wr;
    logic [LINE_WIDTH-1:0] acc_data;
    logic                  acc_err;
    logic                  mem_we;

    assign in_idx = addr_i[IDX_W+4:5];

`ifdef DMEM_RESPONDER_ADDR_CHECK_EN
    logic err_q;
    assign in_err = (|addr_i[4:0]) | (|addr_i[ADDR_WIDTH-1:IDX_W+5]);
    assign err_o  = err_q;
`else
    logic unused_addr;
    assign unused_addr = ^{addr_i[4:0], addr_i[ADDR_WIDTH-1:IDX_W+5]};
    assign in_err      = 1'b0;
`endif

    // With LATENCY == 1 the access happens on the accepting edge, so use live inputs there.
    always_comb begin
        go_ack   = 1'b0;
        acc_idx  = idx_q;
        acc_wr   = wr_q;
        acc_data = wdata_q;
        acc_err  = err_lat_q;
        if (state_q == IDLE) begin
            go_ack   = enable_i && (LATENCY == 1);
            acc_idx  = in_idx;
            acc_wr   = write_i;
            acc_data = data_i;
            acc_err  = in_err;
        end else if (state_q == BUSY) begin
            go_ack   = (cnt_q == CNT_W'(1));
        end
    end

    assign mem_we = go_ack && acc_wr && !acc_err;

    always_ff @(posedge clk_i) begin
        if (mem_we) begin
            mem_q[acc_idx] <= acc_data;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            idx_q     <= '0;
            wr_q      <= 1'b0;
            wdata_q   <= '0;
            err_lat_q <= 1'b0;
            ack_q     <= 1'b0;
            rdata_q   <= '0;
`ifdef DMEM_RESPONDER_ADDR_CHECK_EN
            err_q     <= 1'b0;
`endif
        end else begin
            ack_q <= go_ack;
`ifdef DMEM_RESPONDER_ADDR_CHECK_EN
            err_q <= go_ack && acc_err;
`endif
            if (go_ack && !acc_wr) begin
                rdata_q <= acc_err ? '0 : mem_q[acc_idx];
            end
            case (state_q)
                IDLE: begin
                    if (enable_i) begin
                        idx_q     <= in_idx;
                        wr_q      <= write_i;
                        wdata_q   <= data_i;
                        err_lat_q <= in_err;
                        cnt_q     <= CNT_W'(LATENCY - 1);
                        state_q   <= (LATENCY > 1) ? BUSY : ACK;
                    end
                end
                BUSY: begin
                    cnt_q <= cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        state_q <= ACK;
                    end
                end
                ACK: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign ack_o  = ack_q;
    assign data_o = rdata_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: three instances at LATENCY 10, 1 and 3 sharing clock, reset and bus.
// Address-error checks are included when DMEM_RESPONDER_ADDR_CHECK_EN is defined.
module tb_dmem_responder;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         en10 = 1'b0;
    logic         en1 = 1'b0;
    logic         en3 = 1'b0;
    logic         write_s = 1'b0;
    logic [31:0]  addr_s = '0;
    logic [255:0] wdata_s = '0;

    logic         ack10, ack1, ack3;
    logic [255:0] data10, data1, data3;
`ifdef DMEM_RESPONDER_ADDR_CHECK_EN
    logic         err10, err1, err3;
    logic         exp_err_g = 1'b0;
`endif

    int n_vec = 0;
    int n_miss = 0;

    logic [255:0] pat_a5, pat_5a, pat_d1, pat_d2, pat_g, pat_p, pat_q;

    always #5 clk = ~clk;

    dmem_responder #(.LATENCY(10)) u_dut10 (
        .clk_i(clk), .rst_i(rst), .enable_i(en10), .write_i(write_s),
        .addr_i(addr_s), .data_i(wdata_s), .ack_o(ack10),
`ifdef DMEM_RESPONDER_ADDR_CHECK_EN
        .err_o(err10),
`endif
        .data_o(data10)
    );

    dmem_responder #(.LATENCY(1)) u_dut1 (
        .clk_i(clk), .rst_i(rst), .enable_i(en1), .write_i(write_s),
        .addr_i(addr_s), .data_i(wdata_s), .ack_o(ack1),
`ifdef DMEM_RESPONDER_ADDR_CHECK_EN
        .err_o(err1),
`endif
        .data_o(data1)
    );

    dmem_responder #(.LATENCY(3)) u_dut3 (
        .clk_i(clk), .rst_i(rst), .enable_i(en3), .write_i(write_s),
        .addr_i(addr_s), .data_i(wdata_s), .ack_o(ack3),
`ifdef DMEM_RESPONDER_ADDR_CHECK_EN
        .err_o(err3),
`endif
        .data_o(data3)
    );

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_miss++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drive one request into the LATENCY=10 instance; ack must appear after exactly 10 edges.
    task automatic req10(input logic wr, input logic [31:0] a, input logic [255:0] d,
                         input logic garble, input logic hold, input logic [255:0] exp_d,
                         input string tag);
        write_s = wr;
        addr_s  = a;
        wdata_s = d;
        en10    = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            step();
            if (garble && k == 2) begin
                addr_s  = 32'h0000_0040;
                wdata_s = pat_g;
                write_s = ~wr;
            end
            chk({tag, " ack"}, 256'(ack10), 256'(k == 10));
        end
        chk({tag, " data"}, data10, exp_d);
`ifdef DMEM_RESPONDER_ADDR_CHECK_EN
        chk({tag, " err"}, 256'(err10), 256'(exp_err_g));
`endif
        if (!hold) en10 = 1'b0;
        step();
        chk({tag, " ack_clr"}, 256'(ack10), 256'd0);
    endtask

    initial begin
        pat_a5 = {32{8'hA5}};
        pat_5a = {32{8'h5A}};
        pat_d1 = {8{32'h1111_2222}};
        pat_d2 = {8{32'h3333_4444}};
        pat_g  = {8{32'hDEAD_BEEF}};
        pat_p  = {4{64'h0123_4567_89AB_CDEF}};
        pat_q  = {16{16'hC3C3}};

        // Reset values
        step();
        step();
        chk("rst ack10", 256'(ack10), 256'd0);
        chk("rst data10", data10, 256'd0);
        chk("rst ack1", 256'(ack1), 256'd0);
        chk("rst ack3", 256'(ack3), 256'd0);
`ifdef DMEM_RESPONDER_ADDR_CHECK_EN
        chk("rst err10", 256'(err10), 256'd0);
`endif
        rst = 1'b1;
        step();

        // Write then back-to-back read of the same line
        req10(1'b1, 32'h0000_0400, pat_a5, 1'b0, 1'b1, 256'd0, "wr400");
        req10(1'b0, 32'h0000_0400, '0, 1'b0, 1'b0, pat_a5, "rd400");

        // Abort a write with reset mid-BUSY
        write_s = 1'b1;
        addr_s  = 32'h0000_0400;
        wdata_s = pat_5a;
        en10    = 1'b1;
        step();
        step();
        step();
        #3 rst = 1'b0;
        #1;
        chk("async rst ack", 256'(ack10), 256'd0);
        chk("async rst data", data10, 256'd0);
        for (int k = 0; k < 3; k++) begin
            step();
            chk("in rst ack", 256'(ack10), 256'd0);
            chk("in rst data", data10, 256'd0);
        end
        rst  = 1'b1;
        en10 = 1'b0;
        for (int k = 0; k < 12; k++) begin
            step();
            chk("post abort ack", 256'(ack10), 256'd0);
            chk("post abort data", data10, 256'd0);
        end
        req10(1'b0, 32'h0000_0400, '0, 1'b0, 1'b0, pat_a5, "rd400 after abort");

        // Inputs changing during BUSY must not affect the latched request
        req10(1'b1, 32'h0000_0040, pat_d2, 1'b0, 1'b0, pat_a5, "wr40");
        req10(1'b1, 32'h0000_0020, pat_d1, 1'b1, 1'b0, pat_a5, "wr20 garbled");
        req10(1'b0, 32'h0000_0020, '0, 1'b0, 1'b0, pat_d1, "rd20");
        req10(1'b0, 32'h0000_0040, '0, 1'b0, 1'b0, pat_d2, "rd40");

`ifndef DMEM_RESPONDER_ADDR_CHECK_EN
        // Index wraps modulo DEPTH lines
        req10(1'b1, 32'h0000_3FE0, pat_q, 1'b0, 1'b0, pat_d2, "wr3fe0");
        req10(1'b1, 32'h0000_4000, pat_p, 1'b0, 1'b0, pat_d2, "wr4000");
        req10(1'b0, 32'h0000_0000, '0, 1'b0, 1'b0, pat_p, "rd0 wrap");
        req10(1'b0, 32'h0000_3FE0, '0, 1'b0, 1'b0, pat_q, "rd3fe0");
        req10(1'b0, 32'h0000_0003, '0, 1'b0, 1'b0, pat_p, "rd unaligned");
`endif

        // Back-to-back reads with enable held across ack
        write_s = 1'b0;
        addr_s  = 32'h0000_0060;
        en1     = 1'b1;
        en3     = 1'b1;
        for (int k = 1; k <= 9; k++) begin
            step();
            chk("b2b ack lat1", 256'(ack1), 256'((k == 1) || (k == 3)));
            chk("b2b ack lat3", 256'(ack3), 256'((k == 3) || (k == 7)));
            if (k == 3) en1 = 1'b0;
            if (k == 7) en3 = 1'b0;
        end

`ifdef DMEM_RESPONDER_ADDR_CHECK_EN
        exp_err_g = 1'b1;
        req10(1'b1, 32'h0000_0404, {32{8'hF0}}, 1'b0, 1'b0, pat_d2, "wr404 err");
        exp_err_g = 1'b0;
        req10(1'b0, 32'h0000_0400, '0, 1'b0, 1'b0, pat_a5, "rd400 unchanged");
        exp_err_g = 1'b1;
        req10(1'b0, 32'h8000_0000, '0, 1'b0, 1'b0, 256'd0, "rd80000000 err");
        exp_err_g = 1'b0;
        req10(1'b0, 32'h0000_0020, '0, 1'b0, 1'b0, pat_d1, "rd20 no err");
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Off-chip data-memory model/controller on the responder side of the 256-bit cache-line interface driven by the data cache.
- Accepts one line read or line write at a time and answers after a fixed access latency with a single-cycle ack.
- Line reads return the full 256-bit line.
- Sits at the top level beside the CPU, wired to its mem_* ports.

Parameters:
- LINE_WIDTH, 256, bits per cache line (data bus width)
- ADDR_WIDTH, 32, byte-address width
- DEPTH, 512, number of lines stored; power of two
- LATENCY, 10, cycles from request accept to ack; legal range 1..255

Ports:
- clk_i  in  1  clock, rising edge
- rst_i  in  1  reset, asynchronous, active-low
- enable_i  in  1  request valid; initiator holds it high until ack
- write_i  in  1  1 = line write, 0 = line read; sampled at accept
- addr_i  in  ADDR_WIDTH  byte address of the line
- data_i  in  LINE_WIDTH  write line data; sampled at accept
- ack_o  out  1  one-cycle completion pulse
- data_o  out  LINE_WIDTH  read line data; valid while ack_o is high for reads

Behaviour:
- Reset: rst_i low forces the following immediately, independent of clk_i:
  - state = IDLE, counter = 0
  - ack_o = 0, data_o = 0
  - latched request (addr, write, data) cleared
  - Storage array is not reset.
- Indexing: line index = addr_i[log2(DEPTH)+4 : 5].
  - Bits [4:0] are ignored (line aligned).
  - Bits above the index are ignored, so addresses wrap modulo DEPTH lines.
- FSM, state IDLE:
  - ack_o = 0.
  - On a rising edge with enable_i = 1: latch index, write_i and data_i; load counter = LATENCY-1.
  - Next state: BUSY if LATENCY > 1, else ACK.
- FSM, state BUSY:
  - Counter decrements each edge.
  - When counter reaches 0 at an edge, next state is ACK.
  - Inputs are ignored; changes to addr_i, data_i and write_i after accept have no effect.
- FSM, state ACK:
  - ack_o = 1 for exactly one cycle.
  - Write: the line is written into the array at the edge entering ACK.
  - Read: data_o is loaded from the array at the edge entering ACK.
  - Next edge returns to IDLE.
- Latency: request accepted at edge N produces ack_o high from edge N+LATENCY until edge N+LATENCY+1.
- data_o holding:
  - data_o holds its last read value through IDLE and BUSY.
  - data_o is not altered by writes.
- Back-to-back requests: if enable_i is still high in the IDLE cycle following ACK, that is a new request. Minimum request-to-request spacing is therefore LATENCY+1 cycles.
- Read after write to the same line returns the newly written data.
- Reset asserted mid-transaction: transaction aborted, no array write, no ack.
- enable_i dropped before ack: the transaction still completes and acks.
- X on enable_i while in IDLE is a bench error. The block does not need to tolerate it.

Optional Feature:
- Macro: DMEM_RESPONDER_ADDR_CHECK_EN
- With the macro defined:
  - Adds output port err_o (1 bit, reset 0).
  - A request is erroneous if addr_i[4:0] != 0, or if any addr_i bit above the index field is 1.
  - err_o is high in the same cycle as ack_o for an erroneous request.
  - Erroneous writes do not modify the array.
  - Erroneous reads return data_o = 0.
  - Latency is unchanged.
- Without the macro: no err_o port; unaligned and out-of-range addresses wrap silently as described above.

Test Plan:
1. Reset and idle: rst_i low for 3 cycles mid-BUSY, then high, enable_i = 0 -> ack_o = 0 and data_o = 0 throughout; no ack ever appears for the aborted request.
2. Single write then read, LATENCY = 10:
   - Write addr 0x0000_0400 with data 256'hA5..A5 at edge 0 -> ack_o high exactly in cycle 10 only.
   - Read of the same address accepted at edge 11 -> ack at edge 21, data_o = 256'hA5..A5.
3. Input volatility: change addr_i and data_i to garbage during BUSY of a write to 0x20 -> line 1 holds the originally latched data; line at the garbage address is unchanged.
4. Wrap-around, DEPTH = 512:
   - Write 0x0000_4000 (index 0) with pattern P.
   - Read 0x0000_0000 -> data_o = P.
   - Read 0x0000_3FE0 -> index 511, untouched value.
5. Back-to-back with enable_i held high across ack:
   - Two reads at LATENCY = 1 -> acks at edges 1 and 3.
   - At LATENCY = 3 -> acks at edges 3 and 7.
6. With DMEM_RESPONDER_ADDR_CHECK_EN:
   - Write to 0x0000_0404 -> err_o = 1 with ack_o; the line at 0x400 is unchanged.
   - Read 0x8000_0000 -> err_o = 1, data_o = 0.
   - Aligned in-range access -> err_o = 0.
